// File: rtl/calc_pkg.sv
// Shared constants for the calculator front end: opcodes, key types and
// the key-sequencer state encoding.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam logic [1:0] KEY_DIGIT = 2'b00;
  localparam logic [1:0] KEY_OP    = 2'b01;
  localparam logic [1:0] KEY_EQ    = 2'b10;
  localparam logic [1:0] KEY_CLR   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A    = 3'd1,
    S_OP   = 3'd2,
    S_B    = 3'd3,
    S_EXEC = 3'd4,
    S_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/calc_key_sequencer.sv
// Key-event sequencer in front of the combinational calculator: builds
// operands and opcode from a key stream and registers the returned result.
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int W   = 4,
  parameter int OPW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_valid,
  output logic           key_ready,
  input  logic [1:0]     key_type,
  input  logic [W-1:0]   key_data,
  output logic [W-1:0]   calc_a,
  output logic [W-1:0]   calc_b,
  output logic [OPW-1:0] calc_op,
  input  logic [W-1:0]   calc_result,
  output logic [W-1:0]   result,
  output logic           result_valid,
  output logic           key_err
);

  state_t state, state_nxt;

  logic           accept;
  logic           is_digit, is_op, is_eq, is_clr;
  logic           do_clr, do_err, do_exec;
  logic           ld_a, ld_b, ld_op, ld_pend;
  logic [OPW-1:0] pend_op;
  logic           pend_flag;

  assign accept   = key_valid && key_ready;
  assign is_digit = (key_type == KEY_DIGIT);
  assign is_op    = (key_type == KEY_OP);
  assign is_eq    = (key_type == KEY_EQ);
  assign is_clr   = (key_type == KEY_CLR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // S_EXEC always leaves after one cycle; elsewhere only an accepted key moves us.
  always_comb begin
    state_nxt = state;
    if (state == S_EXEC) begin
      state_nxt = pend_flag ? S_OP : S_DONE;
    end else if (accept) begin
      if (is_clr) begin
        state_nxt = S_IDLE;
      end else begin
        case (state)
          S_IDLE:  if (is_digit) state_nxt = S_A;
          S_A:     if (is_op) state_nxt = S_OP;
          S_OP:    if (is_digit) state_nxt = S_B;
          S_B:     if (is_op || is_eq) state_nxt = S_EXEC;
          S_DONE: begin
            if (is_digit)      state_nxt = S_A;
            else if (is_op)    state_nxt = S_OP;
            else if (is_eq)    state_nxt = S_EXEC;
          end
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    key_ready = (state != S_EXEC);
    do_exec   = (state == S_EXEC);
    do_clr    = 1'b0;
    do_err    = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_op     = 1'b0;
    ld_pend   = 1'b0;
    if (accept) begin
      do_clr = is_clr;
      case (state)
        S_IDLE: begin
          ld_a   = is_digit;
          do_err = is_op || is_eq;
        end
        S_A: begin
          ld_a   = is_digit;
          ld_op  = is_op;
          do_err = is_eq;
        end
        S_OP: begin
          ld_b   = is_digit;
          ld_op  = is_op;
          do_err = is_eq;
        end
        S_B: begin
          ld_b    = is_digit;
          ld_pend = is_op;
        end
        S_DONE: begin
          ld_a  = is_digit;
          ld_op = is_op;
        end
        default: ;
      endcase
    end
  end

  // An operator ending operand B is parked in pend_op until the result lands in A.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      calc_a       <= '0;
      calc_b       <= '0;
      calc_op      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      key_err      <= 1'b0;
      pend_op      <= '0;
      pend_flag    <= 1'b0;
    end else begin
      result_valid <= do_exec;
      key_err      <= do_err;
      if (do_clr) begin
        calc_a    <= '0;
        calc_b    <= '0;
        calc_op   <= '0;
        result    <= '0;
        pend_op   <= '0;
        pend_flag <= 1'b0;
      end else if (do_exec) begin
        result <= calc_result;
        calc_a <= calc_result;
        if (pend_flag) begin
          calc_op   <= pend_op;
          pend_flag <= 1'b0;
        end
      end else begin
        if (ld_a)  calc_a  <= key_data;
        if (ld_b)  calc_b  <= key_data;
        if (ld_op) calc_op <= key_data[OPW-1:0];
        if (ld_pend) begin
          pend_op   <= key_data[OPW-1:0];
          pend_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Self-checking bench for calc_key_sequencer with a combinational calculator
// attached and a key-level reference model.
module tb_calc_key_sequencer;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic [1:0] key_type = 2'b00;
  logic [3:0] key_data = 4'd0;
  logic [3:0] calc_a, calc_b, calc_result, result;
  logic [1:0] calc_op;
  logic       result_valid, key_err;

  int n_checks = 0;
  int n_fail   = 0;

  // observations captured one and two cycles after each accepted key
  logic       p1_err, p1_rv, p1_ready, p2_err, p2_rv;
  logic [3:0] p2_res, p2_a, p2_b;
  logic [1:0] p2_op;

  // reference model state
  localparam int PH_EMPTY = 0, PH_A = 1, PH_OP = 2, PH_B = 3, PH_DONE = 4;
  int         m_phase;
  logic [3:0] m_a, m_b, m_res;
  logic [1:0] m_op, m_pend_op;
  logic       m_pend;

  always #5 clk = ~clk;

  // the calculator datapath this sequencer feeds
  always_comb begin
    case (calc_op)
      2'b00:   calc_result = calc_a + calc_b;
      2'b01:   calc_result = calc_a - calc_b;
      2'b10:   calc_result = calc_a & calc_b;
      default: calc_result = calc_a | calc_b;
    endcase
  end

  calc_key_sequencer #(.W(4), .OPW(2)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_type(key_type), .key_data(key_data), .calc_a(calc_a), .calc_b(calc_b),
    .calc_op(calc_op), .calc_result(calc_result), .result(result),
    .result_valid(result_valid), .key_err(key_err)
  );

  function automatic logic [3:0] ref_calc(input int a, input int b, input int op);
    int r;
    case (op)
      0:       r = (a + b) % 16;
      1:       r = (a - b + 16) % 16;
      2:       r = a & b;
      default: r = a | b;
    endcase
    return 4'(r);
  endfunction

  task automatic model_reset();
    m_phase = PH_EMPTY; m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_pend_op = 0; m_pend = 0;
  endtask

  task automatic model_key(input logic [1:0] t, input logic [3:0] d,
                           output logic e_err, output logic e_exec);
    e_err = 0; e_exec = 0;
    if (t == KEY_CLR) begin
      model_reset();
    end else begin
      case (m_phase)
        PH_EMPTY: if (t == KEY_DIGIT) begin m_a = d; m_phase = PH_A; end else e_err = 1;
        PH_A: begin
          if (t == KEY_DIGIT) m_a = d;
          else if (t == KEY_OP) begin m_op = d[1:0]; m_phase = PH_OP; end
          else e_err = 1;
        end
        PH_OP: begin
          if (t == KEY_DIGIT) begin m_b = d; m_phase = PH_B; end
          else if (t == KEY_OP) m_op = d[1:0];
          else e_err = 1;
        end
        PH_B: begin
          if (t == KEY_DIGIT) m_b = d;
          else begin
            if (t == KEY_OP) begin m_pend = 1; m_pend_op = d[1:0]; end
            e_exec = 1;
          end
        end
        default: begin
          if (t == KEY_DIGIT) begin m_a = d; m_phase = PH_A; end
          else if (t == KEY_OP) begin m_op = d[1:0]; m_phase = PH_OP; end
          else e_exec = 1;
        end
      endcase
      if (e_exec) begin
        m_res = ref_calc(int'(m_a), int'(m_b), int'(m_op));
        m_a = m_res;
        if (m_pend) begin m_op = m_pend_op; m_pend = 0; m_phase = PH_OP; end
        else m_phase = PH_DONE;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0; key_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  // presents one key, waits (bounded) until it is accepted, then samples twice
  task automatic press(input logic [1:0] t, input logic [3:0] d);
    int guard;
    @(negedge clk);
    key_valid = 1; key_type = t; key_data = d;
    guard = 0;
    while (!key_ready && guard < 10) begin @(negedge clk); guard++; end
    if (!key_ready) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL press_timeout: key_ready=%0b required 1", key_ready);
      key_valid = 0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    key_valid = 0;
    p1_err = key_err; p1_rv = result_valid; p1_ready = key_ready;
    @(negedge clk);
    p2_err = key_err; p2_rv = result_valid; p2_res = result;
    p2_a = calc_a; p2_b = calc_b; p2_op = calc_op;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({calc_a, calc_b, calc_op, result, result_valid, key_err} !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_regs: got a=%0d b=%0d op=%0d res=%0d rv=%0b err=%0b required all 0",
               calc_a, calc_b, calc_op, result, result_valid, key_err);
    end
    rst_n = 1;
    @(negedge clk);
    n_checks++;
    if (key_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_ready: got %0b required 1", key_ready);
    end
    model_reset();
  endtask

  task automatic test_basic_add();
    press(KEY_DIGIT, 4'd3); press(KEY_OP, 4'd0); press(KEY_DIGIT, 4'd1);
    n_checks++;
    if (p2_a !== 4'd3 || p2_b !== 4'd1 || p2_op !== 2'd0) begin
      n_fail++; $display("[TB] FAIL add_operands: got a=%0d b=%0d op=%0d required 3 1 0", p2_a, p2_b, p2_op);
    end
    press(KEY_EQ, 4'd0);
    n_checks++;
    if (p1_rv !== 1'b0 || p1_ready !== 1'b0 || p2_rv !== 1'b1 || p2_res !== 4'd4) begin
      n_fail++; $display("[TB] FAIL add_result: got rv1=%0b rdy1=%0b rv2=%0b res=%0d required 0 0 1 4",
                         p1_rv, p1_ready, p2_rv, p2_res);
    end
    @(negedge clk);
    n_checks++;
    if (result_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL add_pulse_width: got rv=%0b required 0", result_valid);
    end
  endtask

  task automatic test_chaining();
    press(KEY_OP, 4'd1); press(KEY_DIGIT, 4'd1); press(KEY_EQ, 4'd0);
    n_checks++;
    if (p2_rv !== 1'b1 || p2_res !== 4'd3) begin
      n_fail++; $display("[TB] FAIL chain_sub: got rv=%0b res=%0d required 1 3", p2_rv, p2_res);
    end
    press(KEY_EQ, 4'd0);
    n_checks++;
    if (p2_rv !== 1'b1 || p2_res !== 4'd2 || p1_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL chain_repeat: got rv=%0b res=%0d err=%0b required 1 2 0", p2_rv, p2_res, p1_err);
    end
  endtask

  task automatic test_wrap_logic();
    press(KEY_DIGIT, 4'd15); press(KEY_OP, 4'd0); press(KEY_DIGIT, 4'd2); press(KEY_EQ, 4'd0);
    n_checks++;
    if (p2_res !== 4'd1) begin
      n_fail++; $display("[TB] FAIL wrap_add: got %0d required 1", p2_res);
    end
    press(KEY_DIGIT, 4'd12); press(KEY_OP, 4'd2); press(KEY_DIGIT, 4'd10); press(KEY_EQ, 4'd0);
    n_checks++;
    if (p2_res !== 4'd8 || p2_rv !== 1'b1) begin
      n_fail++; $display("[TB] FAIL logic_and: got res=%0d rv=%0b required 8 1", p2_res, p2_rv);
    end
  endtask

  task automatic test_illegal_keys();
    apply_reset();
    press(KEY_EQ, 4'd0);
    n_checks++;
    if (p1_err !== 1'b1 || p2_err !== 1'b0 || p1_rv !== 1'b0) begin
      n_fail++; $display("[TB] FAIL idle_eq_err: got err1=%0b err2=%0b rv=%0b required 1 0 0", p1_err, p2_err, p1_rv);
    end
    press(KEY_DIGIT, 4'd5);
    n_checks++;
    if (p2_a !== 4'd5 || p1_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL idle_after_err: got a=%0d err=%0b required 5 0", p2_a, p1_err);
    end
    press(KEY_OP, 4'd0); press(KEY_OP, 4'd1);
    n_checks++;
    if (p1_err !== 1'b0 || p2_op !== 2'd1) begin
      n_fail++; $display("[TB] FAIL op_replace: got err=%0b op=%0d required 0 1", p1_err, p2_op);
    end
    press(KEY_DIGIT, 4'd2); press(KEY_EQ, 4'd0);
    n_checks++;
    if (p2_res !== 4'd3) begin
      n_fail++; $display("[TB] FAIL op_replace_result: got %0d required 3", p2_res);
    end
  endtask

  task automatic test_clear_and_reset();
    press(KEY_DIGIT, 4'd7); press(KEY_OP, 4'd0); press(KEY_DIGIT, 4'd4); press(KEY_EQ, 4'd0);
    press(KEY_DIGIT, 4'd6); press(KEY_OP, 4'd1); press(KEY_DIGIT, 4'd2); press(KEY_CLR, 4'd0);
    n_checks++;
    if ({p2_a, p2_b, p2_op, p2_res, p1_rv, p2_rv, p1_err} !== 17'h0) begin
      n_fail++; $display("[TB] FAIL clear_in_b: got a=%0d b=%0d op=%0d res=%0d rv=%0b/%0b err=%0b required all 0",
                         p2_a, p2_b, p2_op, p2_res, p1_rv, p2_rv, p1_err);
    end
    press(KEY_EQ, 4'd0);
    n_checks++;
    if (p1_err !== 1'b1) begin
      n_fail++; $display("[TB] FAIL clear_to_idle: got err=%0b required 1", p1_err);
    end
    press(KEY_DIGIT, 4'd2); press(KEY_OP, 4'd0); press(KEY_DIGIT, 4'd3); press(KEY_EQ, 4'd0);
    press(KEY_OP, 4'd0); press(KEY_DIGIT, 4'd1);
    @(negedge clk);
    key_valid = 1; key_type = KEY_EQ; key_data = 0;
    @(posedge clk);
    @(negedge clk);
    key_valid = 0; rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    n_checks++;
    if (result_valid !== 1'b0 || result !== 4'd0 || key_ready !== 1'b1 || calc_a !== 4'd0) begin
      n_fail++; $display("[TB] FAIL reset_in_exec: got rv=%0b res=%0d rdy=%0b a=%0d required 0 0 1 0",
                         result_valid, result, key_ready, calc_a);
    end
    @(negedge clk);
    n_checks++;
    if (result_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_in_exec_late: got rv=%0b required 0", result_valid);
    end
    model_reset();
  endtask

  task automatic test_backpressure();
    press(KEY_DIGIT, 4'd4); press(KEY_OP, 4'd0); press(KEY_DIGIT, 4'd4);
    @(negedge clk);
    key_valid = 1; key_type = KEY_EQ; key_data = 0;
    @(posedge clk);
    @(negedge clk);
    key_type = KEY_DIGIT; key_data = 4'd9;
    n_checks++;
    if (key_ready !== 1'b0 || result_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL bp_exec_ready: got rdy=%0b rv=%0b required 0 0", key_ready, result_valid);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (result_valid !== 1'b1 || result !== 4'd8 || calc_a !== 4'd8 || key_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL bp_held_key: got rv=%0b res=%0d a=%0d rdy=%0b required 1 8 8 1",
                         result_valid, result, calc_a, key_ready);
    end
    @(posedge clk);
    @(negedge clk);
    key_valid = 0;
    n_checks++;
    if (calc_a !== 4'd9 || result_valid !== 1'b0 || key_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL bp_accept_after: got a=%0d rv=%0b err=%0b required 9 0 0", calc_a, result_valid, key_err);
    end
    press(KEY_OP, 4'd0); press(KEY_DIGIT, 4'd1); press(KEY_EQ, 4'd0);
    n_checks++;
    if (p2_res !== 4'd10) begin
      n_fail++; $display("[TB] FAIL bp_new_calc: got %0d required 10", p2_res);
    end
  endtask

  task automatic test_random();
    logic [1:0] t;
    logic [3:0] d;
    logic       e_err, e_exec;
    apply_reset();
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 11))
        0, 1, 2, 3, 4: t = KEY_DIGIT;
        5, 6, 7:       t = KEY_OP;
        8, 9, 10:      t = KEY_EQ;
        default:       t = KEY_CLR;
      endcase
      d = 4'($urandom_range(0, 15));
      press(t, d);
      model_key(t, d, e_err, e_exec);
      n_checks++;
      if (p1_err !== e_err || p2_err !== 1'b0) begin
        n_fail++; $display("[TB] FAIL rnd_err[%0d]: got %0b/%0b required %0b/0", i, p1_err, p2_err, e_err);
      end
      n_checks++;
      if (p1_rv !== 1'b0 || p2_rv !== e_exec || p1_ready !== !e_exec) begin
        n_fail++; $display("[TB] FAIL rnd_exec[%0d]: got rv=%0b/%0b rdy=%0b required 0/%0b rdy=%0b",
                           i, p1_rv, p2_rv, p1_ready, e_exec, !e_exec);
      end
      n_checks++;
      if (p2_res !== m_res || p2_a !== m_a || p2_b !== m_b || p2_op !== m_op) begin
        n_fail++; $display("[TB] FAIL rnd_regs[%0d]: got res=%0d a=%0d b=%0d op=%0d required %0d %0d %0d %0d",
                           i, p2_res, p2_a, p2_b, p2_op, m_res, m_a, m_b, m_op);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_chaining();
    test_wrap_logic();
    test_illegal_keys();
    test_clear_and_reset();
    test_backpressure();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
